exwb_skid_reg: RTL and testbench
================================

// Module: exwb_skid_reg
// PURPOSE
//  Parametrised EX->WB pipeline register with a valid/ready elastic handshake and a 2-entry skid buffer.
//  Sits between the execute stage and register-file write-back.
//  Adds over the plain EX/WB latch: stall absorption, synchronous flush, write-enable qualification and an optional forwarding compare.
//  in_ready is registered, so backpressure never forms a combinational path through the stage.
// PARAMETERS
//  DATA_W      8  width of ex_result / ex_result_exwb
//  RD_W        3  width of destination-register index
//  ZERO_REG_HW 1  1: register index 0 is hardwired; a write to rd==0 never asserts reg_write_exwb
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-low reset
//  flush           in   1       synchronous; drops every held entry
//  in_valid        in   1       EX presents a valid instruction result
//  in_ready        out  1       stage can accept this cycle (registered)
//  reg_write_idex  in   1       instruction writes the register file
//  ex_result       in   DATA_W  ALU/execute result
//  rd_idex         in   RD_W    destination register index
//  out_valid       out  1       WB entry valid
//  out_ready       in   1       WB consumes the entry this cycle
//  reg_write_exwb  out  1       = out_valid & held reg_write & ~(ZERO_REG_HW & rd_exwb==0)
//  ex_result_exwb  out  DATA_W  held result
//  rd_exwb         out  RD_W    held destination index
// BEHAVIOUR
//  - Reset (reset==0, async): both slots invalid and data zero.
//    Outputs: out_valid=0, reg_write_exwb=0, ex_result_exwb=0, rd_exwb=0, in_ready=1.
//    Inputs are ignored while reset is low.
//  - Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
//  - Latency: one cycle from accept into an empty stage to out_valid=1.
//  - Slots: MAIN drives the outputs; SKID holds one extra entry. in_ready = ~skid_valid, taken from a flop.
//  - State machine (2-bit):
//    EMPTY: accept -> MAIN<=in, go ONE.
//    ONE: accept & consume -> MAIN<=in, stay ONE.
//    ONE: accept & ~consume -> SKID<=in, go FULL.
//    ONE: consume only -> go EMPTY.
//    FULL: in_ready=0. consume -> MAIN<=SKID, go ONE. Otherwise hold.
//  - Ordering: strict FIFO order; no entry is duplicated or dropped except by flush.
//  - flush=1: next state EMPTY, both valids cleared, data regs unchanged.
//    flush has priority over a same-cycle accept or consume; the accepted beat is discarded.
//  - Data regs load only on their slot's load enable; invalid slots hold stale data.
//    reg_write_exwb is always gated by out_valid, so stale data is never written.
//  - Reset mid-operation drops all entries immediately; no partial write-back.
// CONFIGURATION
//  - Macro EXWB_FWD_EN, when defined, adds:
//    inputs  rs1_id, rs2_id [RD_W]
//    outputs fwd_rs1, fwd_rs2 [1]
//    fwd_rsN = reg_write_exwb & (rd_exwb == rsN_id), purely combinational; 0 during reset.
//  - When EXWB_FWD_EN is undefined, those ports and their logic do not exist.
// STRUCTURE
//  - Package exwb_pkg holds:
//    state encoding: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
//    default widths EXWB_DATA_W=8, EXWB_RD_W=3
//  - One sub-module, exwb_slot, is instantiated twice (MAIN, SKID).
//    It is a load-enabled {reg_write, data, rd} register with async active-low clear.
//  - Top level: FSM, slot muxing, in_ready flop, output gating, optional forward compare.
// TESTING
//  1. Reset & pass-through:
//     Stimulus: reset low, then high; in_valid=1, ex_result=8'hA5, rd_idex=3, reg_write_idex=1, out_ready=1.
//     Response: next cycle out_valid=1, ex_result_exwb=A5, rd_exwb=3, reg_write_exwb=1.
//  2. Backpressure:
//     Stimulus: out_ready=0; send 8'h11, 8'h22, 8'h33 back-to-back.
//     Response: after the 2nd accept in_ready=0 and 8'h33 is held off; on out_ready=1 outputs are 11, 22, 33 in order.
//  3. Flush priority:
//     Stimulus: FULL state; assert flush with in_valid=1 and out_ready=1 in the same cycle.
//     Response: next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
//  4. Zero register:
//     Stimulus: ZERO_REG_HW=1; rd_idex=0, reg_write_idex=1.
//     Response: out_valid=1, reg_write_exwb=0. With ZERO_REG_HW=0, reg_write_exwb=1.
//  5. Async reset mid-stream:
//     Stimulus: state FULL; drop reset between clock edges.
//     Response: outputs zero immediately, in_ready=1, no write-back after release.
//  6. Forwarding (EXWB_FWD_EN defined):
//     Stimulus: held rd_exwb=5 with reg_write_exwb=1; rs1_id=5, rs2_id=4.
//     Response: fwd_rs1=1, fwd_rs2=0. When out_valid=0, both are 0.

Source files
------------

// File: rtl/exwb_pkg.sv
// rtl/exwb_pkg.sv - state encoding and default widths for the EX/WB skid register
package exwb_pkg;

  localparam int EXWB_DATA_W = 8;
  localparam int EXWB_RD_W   = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } exwb_state_e;

endpackage

// File: rtl/exwb_slot.sv
// rtl/exwb_slot.sv - load-enabled {reg_write, data, rd} holding register, async active-low clear
module exwb_slot
  import exwb_pkg::*;
#(
  parameter int DATA_W = EXWB_DATA_W,
  parameter int RD_W   = EXWB_RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] data,
  input  logic [RD_W-1:0]   rd,
  output logic              reg_write_q,
  output logic [DATA_W-1:0] data_q,
  output logic [RD_W-1:0]   rd_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q <= 1'b0;
      data_q      <= '0;
      rd_q        <= '0;
    end else if (load) begin
      reg_write_q <= reg_write;
      data_q      <= data;
      rd_q        <= rd;
    end
  end

endmodule

// File: rtl/exwb_skid_reg.sv
// rtl/exwb_skid_reg.sv - EX->WB elastic pipeline register with 2-entry skid; EXWB_FWD_EN adds forwarding compare
module exwb_skid_reg
  import exwb_pkg::*;
#(
  parameter int DATA_W      = EXWB_DATA_W,
  parameter int RD_W        = EXWB_RD_W,
  parameter int ZERO_REG_HW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_idex,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [RD_W-1:0]   rd_idex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_exwb,
  output logic [DATA_W-1:0] ex_result_exwb,
  output logic [RD_W-1:0]   rd_exwb
`ifdef EXWB_FWD_EN
  ,
  input  logic [RD_W-1:0]   rs1_id,
  input  logic [RD_W-1:0]   rs2_id,
  output logic              fwd_rs1,
  output logic              fwd_rs2
`endif
);

  exwb_state_e       state_q, state_d;
  logic              in_ready_q;
  logic              accept, consume;
  logic              main_ld, skid_ld, main_from_skid;
  logic              main_rw, skid_rw;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;
  logic              main_rw_d;
  logic [DATA_W-1:0] main_data_d;
  logic [RD_W-1:0]   main_rd_d;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered copy of "skid not occupied next cycle" keeps backpressure off any comb path
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_rw_d   = main_from_skid ? skid_rw   : reg_write_idex;
  assign main_data_d = main_from_skid ? skid_data : ex_result;
  assign main_rd_d   = main_from_skid ? skid_rd   : rd_idex;

  exwb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
    .clk         (clk),
    .reset       (reset),
    .load        (main_ld),
    .reg_write   (main_rw_d),
    .data        (main_data_d),
    .rd          (main_rd_d),
    .reg_write_q (main_rw),
    .data_q      (ex_result_exwb),
    .rd_q        (rd_exwb)
  );

  exwb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (skid_ld),
    .reg_write   (reg_write_idex),
    .data        (ex_result),
    .rd          (rd_idex),
    .reg_write_q (skid_rw),
    .data_q      (skid_data),
    .rd_q        (skid_rd)
  );

  // out_valid gating guarantees stale slot contents never reach the register file
  assign reg_write_exwb = out_valid & main_rw & ~((ZERO_REG_HW != 0) && (rd_exwb == '0));

`ifdef EXWB_FWD_EN
  assign fwd_rs1 = reg_write_exwb & (rd_exwb == rs1_id);
  assign fwd_rs2 = reg_write_exwb & (rd_exwb == rs2_id);
`endif

endmodule

// File: tb/tb_exwb_skid_reg.sv
// tb/tb_exwb_skid_reg.sv - directed and random checks of exwb_skid_reg against a FIFO reference model
module tb_exwb_skid_reg;

  typedef struct packed {
    logic       rw;
    logic [7:0] data;
    logic [2:0] rd;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, reg_write_idex, out_ready;
  logic [7:0] ex_result;
  logic [2:0] rd_idex;
  logic       in_ready, out_valid, reg_write_exwb;
  logic [7:0] ex_result_exwb;
  logic [2:0] rd_exwb;
  logic       nz_in_ready, nz_out_valid, nz_reg_write;
  logic [7:0] nz_data;
  logic [2:0] nz_rd;
`ifdef EXWB_FWD_EN
  logic [2:0] rs1_id, rs2_id;
  logic       fwd_rs1, fwd_rs2, nz_fwd1, nz_fwd2;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  exwb_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_idex(reg_write_idex), .ex_result(ex_result), .rd_idex(rd_idex),
    .out_valid(out_valid), .out_ready(out_ready), .reg_write_exwb(reg_write_exwb),
    .ex_result_exwb(ex_result_exwb), .rd_exwb(rd_exwb)
`ifdef EXWB_FWD_EN
    , .rs1_id(rs1_id), .rs2_id(rs2_id), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
`endif
  );

  exwb_skid_reg #(.ZERO_REG_HW(0)) dut_nz (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nz_in_ready),
    .reg_write_idex(reg_write_idex), .ex_result(ex_result), .rd_idex(rd_idex),
    .out_valid(nz_out_valid), .out_ready(out_ready), .reg_write_exwb(nz_reg_write),
    .ex_result_exwb(nz_data), .rd_exwb(nz_rd)
`ifdef EXWB_FWD_EN
    , .rs1_id(rs1_id), .rs2_id(rs2_id), .fwd_rs1(nz_fwd1), .fwd_rs2(nz_fwd2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the queue: front entry is what WB sees, capacity is two
  task automatic check_outputs(input string tag);
    logic ev;
    ent_t f;
    ev = (q.size() != 0);
    f  = ev ? q[0] : '0;
    check({tag, ":in_ready"},     in_ready,       q.size() < 2);
    check({tag, ":out_valid"},    out_valid,      ev);
    check({tag, ":reg_write"},    reg_write_exwb, ev & f.rw & (f.rd != 3'd0));
    check({tag, ":nz_in_ready"},  nz_in_ready,    q.size() < 2);
    check({tag, ":nz_out_valid"}, nz_out_valid,   ev);
    check({tag, ":nz_reg_write"}, nz_reg_write,   ev & f.rw);
    if (ev) begin
      check({tag, ":data"},    ex_result_exwb, f.data);
      check({tag, ":rd"},      rd_exwb,        f.rd);
      check({tag, ":nz_data"}, nz_data,        f.data);
      check({tag, ":nz_rd"},   nz_rd,          f.rd);
    end
`ifdef EXWB_FWD_EN
    check({tag, ":fwd_rs1"}, fwd_rs1, ev & f.rw & (f.rd != 3'd0) & (f.rd == rs1_id));
    check({tag, ":fwd_rs2"}, fwd_rs2, ev & f.rw & (f.rd != 3'd0) & (f.rd == rs2_id));
    check({tag, ":nz_fwd1"}, nz_fwd1, ev & f.rw & (f.rd == rs1_id));
    check({tag, ":nz_fwd2"}, nz_fwd2, ev & f.rw & (f.rd == rs2_id));
`endif
  endtask

  task automatic model_edge();
    bit can_acc;
    ent_t e;
    can_acc = (q.size() < 2);
    e = '{rw: reg_write_idex, data: ex_result, rd: rd_idex};
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && can_acc) q.push_back(e);
    end
  endtask

  task automatic cycle(input string tag, input logic iv, input logic [7:0] d, input logic [2:0] r,
                       input logic rw, input logic ordy, input logic fl);
    in_valid = iv; ex_result = d; rd_idex = r; reg_write_idex = rw; out_ready = ordy; flush = fl;
    #1 check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; reg_write_idex = 1'b1; out_ready = 1'b1;
    ex_result = 8'hEE; rd_idex = 3'd6;
`ifdef EXWB_FWD_EN
    rs1_id = 3'd6; rs2_id = 3'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset:data_zero", ex_result_exwb, 8'h00);
    check("reset:rd_zero",   rd_exwb,        3'd0);
    check_outputs("reset");
    reset = 1'b1;

    // Pass-through: one-cycle latency
    cycle("pt_in",  1'b1, 8'hA5, 3'd3, 1'b1, 1'b1, 1'b0);
    #1;
    check("pt:out_valid", out_valid,      1'b1);
    check("pt:data",      ex_result_exwb, 8'hA5);
    check("pt:rd",        rd_exwb,        3'd3);
    check("pt:reg_write", reg_write_exwb, 1'b1);
    cycle("pt_drain", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure: third beat held off until skid drains
    cycle("bp11", 1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 1'b0);
    cycle("bp22", 1'b1, 8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
    #1 check("bp:in_ready_low", in_ready, 1'b0);
    cycle("bp33_held", 1'b1, 8'h33, 3'd3, 1'b1, 1'b0, 1'b0);
    #1 check("bp:first_out", ex_result_exwb, 8'h11);
    cycle("bp_d1", 1'b1, 8'h33, 3'd3, 1'b1, 1'b1, 1'b0);
    #1 check("bp:second_out", ex_result_exwb, 8'h22);
    cycle("bp_d2", 1'b1, 8'h33, 3'd3, 1'b1, 1'b1, 1'b0);
    #1 check("bp:third_out", ex_result_exwb, 8'h33);
    cycle("bp_d3", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // Flush priority over same-cycle accept/consume
    cycle("fl_a", 1'b1, 8'h44, 3'd4, 1'b1, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 8'h55, 3'd5, 1'b1, 1'b0, 1'b0);
    cycle("fl_go", 1'b1, 8'h77, 3'd7, 1'b1, 1'b1, 1'b1);
    #1;
    check("fl:out_valid", out_valid, 1'b0);
    check("fl:in_ready",  in_ready,  1'b1);
    cycle("fl_idle", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // Zero register
    cycle("z_in", 1'b1, 8'h99, 3'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("z:out_valid",    out_valid,      1'b1);
    check("z:reg_write",    reg_write_exwb, 1'b0);
    check("z:nz_reg_write", nz_reg_write,   1'b1);
    cycle("z_drain", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

`ifdef EXWB_FWD_EN
    rs1_id = 3'd5; rs2_id = 3'd4;
    cycle("fw_in", 1'b1, 8'h5A, 3'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check("fw:rs1_hit",  fwd_rs1, 1'b1);
    check("fw:rs2_miss", fwd_rs2, 1'b0);
    cycle("fw_drain", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("fw:idle_rs1", fwd_rs1, 1'b0);
    check("fw:idle_rs2", fwd_rs2, 1'b0);
`endif

    // Async reset while FULL, asserted between edges
    cycle("ar_a", 1'b1, 8'hC1, 3'd1, 1'b1, 1'b0, 1'b0);
    cycle("ar_b", 1'b1, 8'hC2, 3'd2, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("ar:out_valid", out_valid,      1'b0);
    check("ar:reg_write", reg_write_exwb, 1'b0);
    check("ar:data",      ex_result_exwb, 8'h00);
    check("ar:rd",        rd_exwb,        3'd0);
    check("ar:in_ready",  in_ready,       1'b1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle("ar_after", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
`ifdef EXWB_FWD_EN
      rs1_id = 3'($urandom_range(0, 7));
      rs2_id = 3'($urandom_range(0, 7));
`endif
      cycle("rnd", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
